cmd_deframer: RTL and testbench



---
 rtl/cmd_deframer_pkg.sv | 33 +++
 rtl/cmd_byte_timer.sv | 36 +++
 rtl/cmd_deframer.sv | 138 +++++++++++++
 tb/tb_cmd_deframer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cmd_deframer_pkg.sv
// Shared constants and types for cmd_deframer and the parameter block's command decoder.
package cmd_deframer_pkg;

    localparam logic [31:0] CMD_MAGIC = 32'hF0AA550F;

    typedef enum logic [1:0] {
        StHunt,
        StCmd,
        StCsum,
        StOut
    } state_e;

    // Command word field positions, shared with the parameter block
    localparam int unsigned CMD_GLOBAL_BIT = 31;
    localparam int unsigned CMD_CHAN_HI    = 30;
    localparam int unsigned CMD_CHAN_LO    = 29;
    localparam int unsigned CMD_SLOT_HI    = 28;
    localparam int unsigned CMD_SLOT_LO    = 27;
    localparam int unsigned CMD_NCMD_HI    = 26;
    localparam int unsigned CMD_NCMD_LO    = 23;

    localparam logic [3:0] NCMD_MIN = 4'd1;
    localparam logic [3:0] NCMD_MAX = 4'd10;

    function automatic logic [3:0] cmd_ncmd(input logic [31:0] cmd);
        return cmd[CMD_NCMD_HI:CMD_NCMD_LO];
    endfunction

    function automatic logic ncmd_is_valid(input logic [3:0] ncmd);
        return (ncmd >= NCMD_MIN) && (ncmd <= NCMD_MAX);
    endfunction

endpackage

// File: rtl/cmd_byte_timer.sv
// Idle-clock counter between bytes of a frame; expire pulses on the LIMIT-th idle clock.
module cmd_byte_timer #(
    parameter int unsigned LIMIT = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // A byte arriving in the expiry cycle clears the count and suppresses the timeout
    assign o_expire = i_en & ~i_clear & (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cmd_deframer.sv
// Byte-stream command deframer: hunts for CMD_MAGIC, assembles a 32-bit command word.
// Define CMD_DEFRAMER_CSUM_EN to require a trailing XOR checksum byte per frame.
module cmd_deframer
    import cmd_deframer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter int unsigned ERR_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_vld,
    output logic             o_rx_rdy,
    output logic [31:0]      o_cmd_magic,
    output logic [31:0]      o_cmd_command,
    output logic             o_cmd_vld,
    input  logic             i_cmd_rdy,
    output logic [ERR_W-1:0] o_err_cnt
);

    state_e           state_q, state_d;
    logic [31:0]      hunt_q, hunt_d;
    logic [31:0]      cmd_q, cmd_d;
    logic [1:0]       idx_q, idx_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [31:0]      hunt_shift;
    logic             accept, in_frame, expire, err_inc;
`ifdef CMD_DEFRAMER_CSUM_EN
    logic [7:0]       xor_q, xor_d;
`endif

    assign o_rx_rdy   = ~rst & (state_q != StOut);
    assign accept     = i_rx_vld & o_rx_rdy;
    assign in_frame   = (state_q == StCmd) || (state_q == StCsum);
    assign hunt_shift = {hunt_q[23:0], i_rx_data};

    cmd_byte_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (accept | ~in_frame),
        .i_en     (in_frame),
        .o_expire (expire)
    );

    always_comb begin
        state_d = state_q;
        hunt_d  = '0;  // zero outside HUNT so every entry to HUNT starts clean
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        err_inc = 1'b0;
`ifdef CMD_DEFRAMER_CSUM_EN
        xor_d   = xor_q;
`endif
        unique case (state_q)
            StHunt: begin
                hunt_d = hunt_q;
                if (accept) begin
                    hunt_d = hunt_shift;
                    if (hunt_shift == CMD_MAGIC) begin
                        hunt_d  = '0;
                        idx_d   = '0;
                        state_d = StCmd;
`ifdef CMD_DEFRAMER_CSUM_EN
                        xor_d   = '0;
`endif
                    end
                end
            end
            StCmd: begin
                if (accept) begin
                    cmd_d = {cmd_q[23:0], i_rx_data};
                    idx_d = idx_q + 2'd1;
`ifdef CMD_DEFRAMER_CSUM_EN
                    xor_d = xor_q ^ i_rx_data;
                    if (idx_q == 2'd3) state_d = StCsum;
`else
                    if (idx_q == 2'd3) state_d = StOut;
`endif
                end else if (expire) begin
                    state_d = StHunt;
                    err_inc = 1'b1;
                end
            end
`ifdef CMD_DEFRAMER_CSUM_EN
            StCsum: begin
                if (accept) begin
                    if (i_rx_data == xor_q) begin
                        state_d = StOut;
                    end else begin
                        state_d = StHunt;
                        err_inc = 1'b1;
                    end
                end else if (expire) begin
                    state_d = StHunt;
                    err_inc = 1'b1;
                end
            end
`endif
            StOut: begin
                if (i_cmd_rdy) state_d = StHunt;
            end
            default: state_d = StHunt;
        endcase
    end

    assign err_d = (err_inc && (err_q != '1)) ? err_q + 1'b1 : err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StHunt;
            hunt_q  <= '0;
            cmd_q   <= '0;
            idx_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            hunt_q  <= hunt_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

`ifdef CMD_DEFRAMER_CSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) xor_q <= '0;
        else     xor_q <= xor_d;
    end
`endif

    assign o_cmd_vld     = (state_q == StOut);
    assign o_cmd_magic   = o_cmd_vld ? CMD_MAGIC : '0;
    assign o_cmd_command = cmd_q;
    assign o_err_cnt     = err_q;

endmodule

// File: tb/tb_cmd_deframer.sv
// Scoreboard bench for cmd_deframer; follows CMD_DEFRAMER_CSUM_EN when defined.
module tb_cmd_deframer;
    import cmd_deframer_pkg::*;

    localparam int unsigned TO = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_vld = 1'b0;
    logic        o_rx_rdy;
    logic [31:0] o_cmd_magic, o_cmd_command;
    logic        o_cmd_vld;
    logic        i_cmd_rdy = 1'b1;
    logic [7:0]  o_err_cnt;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    cmd_deframer #(
        .TIMEOUT_CYCLES (TO),
        .ERR_W          (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_rx_data     (i_rx_data),
        .i_rx_vld      (i_rx_vld),
        .o_rx_rdy      (o_rx_rdy),
        .o_cmd_magic   (o_cmd_magic),
        .o_cmd_command (o_cmd_command),
        .o_cmd_vld     (o_cmd_vld),
        .i_cmd_rdy     (i_cmd_rdy),
        .o_err_cnt     (o_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        i_rx_data = b;
        i_rx_vld  = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = o_rx_rdy;
            @(posedge clk);
        end
        #1;
        i_rx_vld = 1'b0;
        if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_magic();
        send_byte(8'hF0); send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0F);
    endtask

    task automatic send_frame(input logic [31:0] cmd);
        send_magic();
        send_byte(cmd[31:24]); send_byte(cmd[23:16]); send_byte(cmd[15:8]); send_byte(cmd[7:0]);
`ifdef CMD_DEFRAMER_CSUM_EN
        send_byte(cmd[31:24] ^ cmd[23:16] ^ cmd[15:8] ^ cmd[7:0]);
`endif
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: pops on each output handshake, checks hold-while-stalled behaviour
    bit          stall_prev = 1'b0;
    logic [31:0] held;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else if (o_cmd_vld) begin
            check("rx_rdy_low_in_out", 32'(o_rx_rdy), 32'd0);
            check("magic", o_cmd_magic, CMD_MAGIC);
            if (stall_prev) check("hold_stable", o_cmd_command, held);
            if (i_cmd_rdy) begin
                if (exp_q.size() == 0) check("unexpected_cmd", o_cmd_command, 32'hxxxxxxxx);
                else check("cmd", o_cmd_command, exp_q.pop_front());
                stall_prev = 1'b0;
            end else begin
                stall_prev = 1'b1;
                held       = o_cmd_command;
            end
        end else begin
            if (stall_prev) check("vld_withdrawn", 32'(o_cmd_vld), 32'd1);
            stall_prev = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        @(negedge clk);
        check("rst_rx_rdy", 32'(o_rx_rdy), 32'd0);
        check("rst_vld", 32'(o_cmd_vld), 32'd0);
        check("rst_cmd", o_cmd_command, 32'd0);
        check("rst_magic", o_cmd_magic, 32'd0);
        check("rst_err", 32'(o_err_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back frame, one-cycle latency and one-cycle valid
        exp_q.push_back(32'h12345678);
        send_frame(32'h12345678);
        @(negedge clk);
        check("latency_vld", 32'(o_cmd_vld), 32'd1);
        @(negedge clk);
        check("vld_one_cycle", 32'(o_cmd_vld), 32'd0);
        check("rx_rdy_back", 32'(o_rx_rdy), 32'd1);
        check("err_after_good", 32'(o_err_cnt), 32'd0);

        // Leading garbage with overlapping magic prefix
        exp_q.push_back(32'h80000102);
        send_byte(8'h00); send_byte(8'hF0);
        send_frame(32'h80000102);
        drain();

        // Downstream stall for 10 cycles
        i_cmd_rdy = 1'b0;
        exp_q.push_back(32'hABCDEF01);
        send_frame(32'hABCDEF01);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_vld", 32'(o_cmd_vld), 32'd1);
            check("stall_data", o_cmd_command, 32'hABCDEF01);
        end
        @(posedge clk); #1;
        i_cmd_rdy = 1'b1;
        exp_q.push_back(32'h00000001);
        send_frame(32'h00000001);
        drain();

        // Timeout after two command bytes; following magic must not be absorbed
        send_magic(); send_byte(8'h11); send_byte(8'h22);
        repeat (TO) @(posedge clk);
        #1;
        @(negedge clk);
        check("timeout_err", 32'(o_err_cnt), 32'd1);
        exp_q.push_back(32'h0BADF00D);
        send_frame(32'h0BADF00D);
        drain();

        // Byte arriving in the would-expire cycle wins
        exp_q.push_back(32'h11223344);
        send_magic(); send_byte(8'h11); send_byte(8'h22);
        repeat (TO - 1) @(posedge clk);
        #1;
        send_byte(8'h33); send_byte(8'h44);
`ifdef CMD_DEFRAMER_CSUM_EN
        send_byte(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
`endif
        drain();
        check("no_timeout_err", 32'(o_err_cnt), 32'd1);

`ifdef CMD_DEFRAMER_CSUM_EN
        // Bad checksum drops the frame
        send_magic();
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        send_byte(8'h00);
        @(negedge clk);
        check("csum_err", 32'(o_err_cnt), 32'd2);
`endif

        // Saturation of the error counter
        for (int i = 0; i < 300; i++) begin
            send_magic(); send_byte(8'h5A);
            repeat (TO) @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("err_saturated", 32'(o_err_cnt), 32'd255);

        // Reset mid-frame discards the partial frame
        send_magic(); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
        rst = 1'b1;
        #1;
        check("midrst_rx_rdy", 32'(o_rx_rdy), 32'd0);
        check("midrst_cmd", o_cmd_command, 32'd0);
        check("midrst_err", 32'(o_err_cnt), 32'd0);
        check("midrst_vld", 32'(o_cmd_vld), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(32'hCAFEBABE);
        send_frame(32'hCAFEBABE);
        drain();
        check("final_err", 32'(o_err_cnt), 32'd0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
